// File: rtl/fft_bfly_pipe.sv
// fft_bfly_pipe: 3-stage radix-2 DIT butterfly, X = A + B*W and Y = A - B*W, with valid/ready flow.
// Define FFT_BFLY_SCALE_EN to halve (floor) the stage-3 results so they can never overflow.
module fft_bfly_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INTEGER    = 23,
    parameter int unsigned FRACTION   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a_re,
    input  logic [DATA_WIDTH-1:0] a_im,
    input  logic [DATA_WIDTH-1:0] b_re,
    input  logic [DATA_WIDTH-1:0] b_im,
    input  logic [DATA_WIDTH-1:0] w_re,
    input  logic [DATA_WIDTH-1:0] w_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] x_re,
    output logic [DATA_WIDTH-1:0] x_im,
    output logic [DATA_WIDTH-1:0] y_re,
    output logic [DATA_WIDTH-1:0] y_im
);
    localparam int unsigned W = DATA_WIDTH;

    if (W != 1 + INTEGER + FRACTION) begin : g_cfg_check
        $error("DATA_WIDTH must equal 1 + INTEGER + FRACTION");
    end

    // Full-precision signed product, floor-shifted back to the Q format, upper bits wrap away.
    function automatic logic [W-1:0] fx_mul(input logic [W-1:0] b, input logic [W-1:0] w);
        logic signed [2*W-1:0] prod;
        prod = (2*W)'($signed(b)) * (2*W)'($signed(w));
        prod = prod >>> FRACTION;
        return W'(prod);
    endfunction

    function automatic logic [W-1:0] bfly_sum(input logic [W-1:0] a, input logic [W-1:0] p,
                                              input logic sub);
`ifdef FFT_BFLY_SCALE_EN
        logic signed [W:0] s;
        s = sub ? ({a[W-1], a} - {p[W-1], p}) : ({a[W-1], a} + {p[W-1], p});
        return W'(s >>> 1);
`else
        return sub ? (a - p) : (a + p);
`endif
    endfunction

    logic         en;
    logic         s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
    logic [W-1:0] rr_q, rr_d, ii_q, ii_d, ri_q, ri_d, ir_q, ir_d;
    logic [W-1:0] a1_re_q, a1_re_d, a1_im_q, a1_im_d;
    logic [W-1:0] a2_re_q, a2_re_d, a2_im_q, a2_im_d;
    logic [W-1:0] p_re_q, p_re_d, p_im_q, p_im_d;
    logic [W-1:0] x_re_q, x_re_d, x_im_q, x_im_d, y_re_q, y_re_d, y_im_q, y_im_d;

    // A single global enable: the whole pipe advances only when the output slot can drain.
    assign en       = !s3_valid_q || out_ready;
    assign in_ready = en;

    always_comb begin
        s1_valid_d = in_valid;
        rr_d       = fx_mul(b_re, w_re);
        ii_d       = fx_mul(b_im, w_im);
        ri_d       = fx_mul(b_re, w_im);
        ir_d       = fx_mul(b_im, w_re);
        a1_re_d    = a_re;
        a1_im_d    = a_im;

        s2_valid_d = s1_valid_q;
        p_re_d     = rr_q - ii_q;
        p_im_d     = ri_q + ir_q;
        a2_re_d    = a1_re_q;
        a2_im_d    = a1_im_q;

        s3_valid_d = s2_valid_q;
        x_re_d     = bfly_sum(a2_re_q, p_re_q, 1'b0);
        x_im_d     = bfly_sum(a2_im_q, p_im_q, 1'b0);
        y_re_d     = bfly_sum(a2_re_q, p_re_q, 1'b1);
        y_im_d     = bfly_sum(a2_im_q, p_im_q, 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            rr_q       <= '0;
            ii_q       <= '0;
            ri_q       <= '0;
            ir_q       <= '0;
            a1_re_q    <= '0;
            a1_im_q    <= '0;
            a2_re_q    <= '0;
            a2_im_q    <= '0;
            p_re_q     <= '0;
            p_im_q     <= '0;
            x_re_q     <= '0;
            x_im_q     <= '0;
            y_re_q     <= '0;
            y_im_q     <= '0;
        end else if (en) begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            rr_q       <= rr_d;
            ii_q       <= ii_d;
            ri_q       <= ri_d;
            ir_q       <= ir_d;
            a1_re_q    <= a1_re_d;
            a1_im_q    <= a1_im_d;
            a2_re_q    <= a2_re_d;
            a2_im_q    <= a2_im_d;
            p_re_q     <= p_re_d;
            p_im_q     <= p_im_d;
            x_re_q     <= x_re_d;
            x_im_q     <= x_im_d;
            y_re_q     <= y_re_d;
            y_im_q     <= y_im_d;
        end
    end

    // Masking with rst keeps out_valid low for the whole reset cycle, not just after the edge.
    assign out_valid = s3_valid_q && !rst;
    assign x_re      = x_re_q;
    assign x_im      = x_im_q;
    assign y_re      = y_re_q;
    assign y_im      = y_im_q;

endmodule
